spi_peripheral: RTL and testbench
=================================

Name: spi_peripheral

Overview:
SPI target (mode 0, write-only) that receives 16-bit register-write frames from an external controller. It holds the five 8-bit control registers that feed pwm_peripheral: output enables, PWM enables and duty cycle. SCLK, COPI and nCS are asynchronous to clk, so they are synchronized internally and edge-detected in the clk domain. The block sits directly upstream of pwm_peripheral in the top-level wrapper; its SPI pins come from ui_in[2:0].

Parameters:
SYNC_STAGES, 2, flip-flop depth of each input synchronizer (minimum 2).
MAX_ADDR, 7'h04, highest valid register address; writes above it are discarded.

Ports:
clk  input  1  system clock; all state is in this domain.
rst_n  input  1  reset, asynchronous and active-low.
nCS  input  1  SPI chip select, active-low, asynchronous to clk.
SCLK  input  1  SPI clock, asynchronous to clk, idles low.
COPI  input  1  SPI data, controller to peripheral, MSB first.
en_reg_out_7_0  output  8  register 0x00, output enables for bits 7:0.
en_reg_out_15_8  output  8  register 0x01, output enables for bits 15:8.
en_reg_pwm_7_0  output  8  register 0x02, PWM enables for bits 7:0.
en_reg_pwm_15_8  output  8  register 0x03, PWM enables for bits 15:8.
pwm_duty_cycle  output  8  register 0x04, PWM duty cycle.

Behaviour:
- Reset: all five outputs are 8'h00. Shift register, bit counter and overrun flag are cleared. Synchronizers reset to idle: nCS high, SCLK low, COPI low.
- Reset mid-frame: the partial frame is lost. No register is written until a later complete frame arrives after reset is released.
- Synchronization: each of nCS, SCLK and COPI passes through SYNC_STAGES flops, plus one history flop for edge detection.
  - Edge pulses are single-cycle: sclk_rise, ncs_fall, ncs_rise.
  - COPI is taken from the same synchronizer depth as SCLK, so the COPI value used is the one aligned with the SCLK edge.
- Timing requirement on the controller: SCLK high and low phases each at least 3 clk periods; nCS setup/hold to SCLK at least 3 clk periods. Behaviour outside these limits is undefined.
- Frame format: 16 bits, MSB first.
  - Bit 15 is R/W (1 = write).
  - Bits 14:8 are the address.
  - Bits 7:0 are the data.
- Receive sequence:
  - ncs_fall clears the bit counter and overrun flag.
  - On each sclk_rise while synchronized nCS is low: shift_reg <= {shift_reg[14:0], copi_sync} and increment the counter.
  - The counter saturates: if a 17th bit arrives, overrun is set and further bits are ignored.
  - sclk_rise while nCS is high is ignored.
- Commit, on ncs_rise. A register is written only if all of the following hold:
  - count == 16;
  - overrun is 0;
  - shift_reg[15] == 1;
  - address <= MAX_ADDR.
- Otherwise the frame is silently discarded, and registers hold their values. This covers reads (R/W = 0), short frames, long frames and bad addresses.
- Commit latency: the target register updates on the (SYNC_STAGES+1)-th rising clk edge at which raw nCS is sampled high. With the default, that is the 3rd edge after nCS rises.
- Exactly one register is written per valid frame; the others are unchanged.
- Back-to-back frames: nCS high for at least 3 clk periods between frames is sufficient. The commit of frame N always completes before the ncs_fall of frame N+1 is processed.
- No read-back path exists. COPI-only; there is no CIPO.

Decomposition:
- Package spi_regs_pkg holds:
  - address constants ADDR_EN_OUT_LO = 7'h00, ADDR_EN_OUT_HI = 7'h01, ADDR_EN_PWM_LO = 7'h02, ADDR_EN_PWM_HI = 7'h03, ADDR_DUTY = 7'h04;
  - FRAME_BITS = 16;
  - the frame field bit positions.
- Sub-module sync_edge: a SYNC_STAGES-deep synchronizer with registered history, outputting the synced level, rise pulse and fall pulse. It is instantiated three times (nCS, SCLK, COPI; edges unused for COPI).

Test Plan:
- Reset, then frame 0x80F0 (write, addr 0x00, data 0xF0) -> en_reg_out_7_0 = 0xF0 three clk edges after nCS rises; all other outputs remain 0x00.
- Writes 0x8180, 0x8255, 0x83AA, 0x8440 back-to-back with 3 clk nCS-high gaps -> en_reg_out_15_8 = 0x80, en_reg_pwm_7_0 = 0x55, en_reg_pwm_15_8 = 0xAA, pwm_duty_cycle = 0x40.
- After duty = 0x40: frame 0x04FF (read, addr 0x04) -> duty stays 0x40. Frame 0x85FF (addr 0x05) -> all registers unchanged.
- Frame aborted after 15 bits, and a 17-bit frame 0x84FF followed by one extra bit -> both discarded, duty stays 0x40. The next valid 0x8411 -> duty = 0x11.
- rst_n asserted after 8 bits of 0x84CC, then released, then frame 0x8001 -> all outputs 0x00 through reset; afterwards only en_reg_out_7_0 = 0x01.
- SCLK pulses while nCS is high, then a valid 0x8222 -> pulses ignored, en_reg_pwm_7_0 = 0x22.

Source files
------------

// File: rtl/spi_regs_pkg.sv
// Shared constants for the SPI register-write target:
// register addresses and the 16-bit frame layout.
package spi_regs_pkg;
  localparam int FRAME_BITS = 16;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  localparam int RW_BIT   = 15;
  localparam int ADDR_MSB = 14;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;
endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with a history flop for
// single-cycle rise/fall pulses in the clk domain.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic [STAGES-1:0] r_sync;
  logic              r_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_hist <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_hist <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = o_level & ~r_hist;
  assign o_fall  = ~o_level & r_hist;
endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 write-only target holding the five
// control registers consumed by pwm_peripheral.
module spi_peripheral
  import spi_regs_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       nCS,
  input  logic       SCLK,
  input  logic       COPI,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);
  logic w_ncs, w_ncs_rise, w_ncs_fall;
  logic w_sclk, w_sclk_rise, w_sclk_fall_unused;
  logic w_copi, w_copi_rise_unused, w_copi_fall_unused;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs (
    .clk(clk), .rst_n(rst_n), .i_async(nCS),
    .o_level(w_ncs), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst_n(rst_n), .i_async(SCLK),
    .o_level(w_sclk), .o_rise(w_sclk_rise),
    .o_fall(w_sclk_fall_unused)
  );

  // Same depth as SCLK so the sampled bit lines up with its edge
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_copi (
    .clk(clk), .rst_n(rst_n), .i_async(COPI),
    .o_level(w_copi), .o_rise(w_copi_rise_unused),
    .o_fall(w_copi_fall_unused)
  );

  logic [FRAME_BITS-1:0] r_shift;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_ovr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_ovr   <= 1'b0;
    end else if (w_ncs_fall) begin
      r_cnt <= '0;
      r_ovr <= 1'b0;
    end else if (w_sclk_rise && !w_ncs) begin
      if (r_cnt == CNT_W'(FRAME_BITS)) begin
        r_ovr <= 1'b1;
      end else begin
        r_shift <= {r_shift[FRAME_BITS-2:0], w_copi};
        r_cnt   <= r_cnt + CNT_W'(1);
      end
    end
  end

  logic       w_rw;
  logic [6:0] w_addr;
  logic [7:0] w_data;
  logic       w_commit;

  assign w_rw   = r_shift[RW_BIT];
  assign w_addr = r_shift[ADDR_MSB:ADDR_LSB];
  assign w_data = r_shift[DATA_MSB:DATA_LSB];

  assign w_commit = w_ncs_rise && !r_ovr && w_rw
                 && (r_cnt == CNT_W'(FRAME_BITS))
                 && (w_addr <= MAX_ADDR);

  logic [7:0] r_out_lo, r_out_hi;
  logic [7:0] r_pwm_lo, r_pwm_hi;
  logic [7:0] r_duty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_lo <= 8'h00;
      r_out_hi <= 8'h00;
      r_pwm_lo <= 8'h00;
      r_pwm_hi <= 8'h00;
      r_duty   <= 8'h00;
    end else if (w_commit) begin
      unique case (w_addr)
        ADDR_EN_OUT_LO: r_out_lo <= w_data;
        ADDR_EN_OUT_HI: r_out_hi <= w_data;
        ADDR_EN_PWM_LO: r_pwm_lo <= w_data;
        ADDR_EN_PWM_HI: r_pwm_hi <= w_data;
        ADDR_DUTY:      r_duty   <= w_data;
        default: ;
      endcase
    end
  end

  assign en_reg_out_7_0  = r_out_lo;
  assign en_reg_out_15_8 = r_out_hi;
  assign en_reg_pwm_7_0  = r_pwm_lo;
  assign en_reg_pwm_15_8 = r_pwm_hi;
  assign pwm_duty_cycle  = r_duty;
endmodule

// File: tb/tb_spi_peripheral.sv
// Self-checking bench for spi_peripheral: table of frames
// with expected register images, plus reset/noise sequences.
module tb_spi_peripheral;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       nCS = 1'b1;
  logic       SCLK = 1'b0;
  logic       COPI = 1'b0;
  logic [7:0] out_lo, out_hi, pwm_lo, pwm_hi, duty;

  int n_tests = 0;
  int n_fail  = 0;

  // Image order: {duty, pwm_hi, pwm_lo, out_hi, out_lo}
  logic [39:0] sb_q[$];

  typedef struct {
    string       name;
    logic [31:0] bits;
    int          nbits;
    logic [39:0] exp;
  } vec_t;

  vec_t vecs[9];

  spi_peripheral dut (
    .clk(clk), .rst_n(rst_n), .nCS(nCS), .SCLK(SCLK), .COPI(COPI),
    .en_reg_out_7_0(out_lo), .en_reg_out_15_8(out_hi),
    .en_reg_pwm_7_0(pwm_lo), .en_reg_pwm_15_8(pwm_hi),
    .pwm_duty_cycle(duty)
  );

  always #5 clk = ~clk;

  task automatic check8(input string name, input logic [7:0] act,
                        input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [39:0] exp);
    check8({name, ".out_lo"}, out_lo, exp[7:0]);
    check8({name, ".out_hi"}, out_hi, exp[15:8]);
    check8({name, ".pwm_lo"}, pwm_lo, exp[23:16]);
    check8({name, ".pwm_hi"}, pwm_hi, exp[31:24]);
    check8({name, ".duty"},   duty,   exp[39:32]);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends n bits MSB first; optionally leaves nCS low afterwards
  task automatic send_bits(input logic [31:0] bits, input int n,
                           input bit raise);
    nCS = 1'b0;
    wait_neg(4);
    for (int i = n - 1; i >= 0; i--) begin
      COPI = bits[i];
      wait_neg(4);
      SCLK = 1'b1;
      wait_neg(4);
      SCLK = 1'b0;
    end
    wait_neg(4);
    if (raise) nCS = 1'b1;
  endtask

  task automatic wait_commit();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input string name, input logic [31:0] bits,
                           input int n, input logic [39:0] exp);
    logic [39:0] e;
    sb_q.push_back(exp);
    send_bits(bits, n, 1'b1);
    wait_commit();
    e = sb_q.pop_front();
    check_all(name, e);
    wait_neg(1);
  endtask

  initial begin
    vecs[0] = '{"w_out_hi",  32'h8180,  16, 40'h00_00_00_80_F0};
    vecs[1] = '{"w_pwm_lo",  32'h8255,  16, 40'h00_00_55_80_F0};
    vecs[2] = '{"w_pwm_hi",  32'h83AA,  16, 40'h00_AA_55_80_F0};
    vecs[3] = '{"w_duty",    32'h8440,  16, 40'h40_AA_55_80_F0};
    vecs[4] = '{"read",      32'h04FF,  16, 40'h40_AA_55_80_F0};
    vecs[5] = '{"bad_addr",  32'h85FF,  16, 40'h40_AA_55_80_F0};
    vecs[6] = '{"short15",   32'h4211,  15, 40'h40_AA_55_80_F0};
    vecs[7] = '{"long17",    32'h109FF, 17, 40'h40_AA_55_80_F0};
    vecs[8] = '{"w_duty2",   32'h8411,  16, 40'h11_AA_55_80_F0};

    wait_neg(3);
    check_all("reset", 40'h0);
    rst_n = 1'b1;
    wait_neg(3);

    // First write with commit-latency check
    send_bits(32'h80F0, 16, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check8("latency_early", out_lo, 8'h00);
    @(posedge clk);
    #1;
    check_all("w_out_lo", 40'h00_00_00_00_F0);
    wait_neg(1);

    foreach (vecs[i])
      run_frame(vecs[i].name, vecs[i].bits, vecs[i].nbits, vecs[i].exp);

    // Reset in the middle of a frame
    send_bits(32'h84, 8, 1'b0);
    rst_n = 1'b0;
    wait_neg(2);
    check_all("mid_reset", 40'h0);
    nCS = 1'b1;
    COPI = 1'b0;
    wait_neg(4);
    check_all("in_reset", 40'h0);
    rst_n = 1'b1;
    wait_neg(4);
    check_all("post_reset", 40'h0);
    run_frame("after_rst", 32'h8001, 16, 40'h00_00_00_00_01);

    // SCLK activity with nCS high must be ignored
    for (int k = 0; k < 5; k++) begin
      COPI = 1'b1;
      SCLK = 1'b1;
      wait_neg(4);
      SCLK = 1'b0;
      wait_neg(4);
    end
    check_all("noise", 40'h00_00_00_00_01);
    run_frame("after_noise", 32'h8222, 16, 40'h00_00_22_00_01);

    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard: %0d left, expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
